// File: rtl/pdp8_pkg.sv
// Shared PDP-8 pipeline constants and the decoded-instruction structs
// passed from fetch/decode to EXEC.
package pdp8_pkg;
  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;
  localparam logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'o0200;

  typedef struct packed {
    logic AND;
    logic TAD;
    logic ISZ;
    logic DCA;
    logic JMS;
    logic JMP;
    logic [ADDR_WIDTH-1:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP;
    logic IAC;
    logic RAL;
    logic RTL;
    logic RAR;
    logic RTR;
    logic CML;
    logic CMA;
    logic CIA;
    logic CLL;
    logic CLA;
    logic CLA_CLL;
    logic HLT;
    logic SMA;
    logic SZA;
    logic SNL;
    logic SKP;
    logic SPA;
    logic SNA;
    logic SZL;
  } pdp_op7_opcode_s;
endpackage

// File: rtl/pdp8_fetch_decode.sv
// PDP-8 fetch/decode: fetches, resolves the EA and holds the decoded op for EXEC.
// Define PDP8_INDIRECT_EN to enable one level of indirect addressing.
module pdp8_fetch_decode
  import pdp8_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] PC_value,
  output logic                  ifu_rd_req,
  output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output pdp_mem_opcode_s       pdp_mem_opcode,
  output pdp_op7_opcode_s       pdp_op7_opcode
);

  typedef enum logic [3:0] {
    IDLE, FETCH, FETCH_WAIT, DECODE,
`ifdef PDP8_INDIRECT_EN
    IND_FETCH, IND_WAIT,
`endif
    WAIT_STALL_HI, WAIT_STALL_LO, HALT
  } state_e;

  state_e                state, state_n;
  logic [DATA_WIDTH-1:0] ir;
  logic [ADDR_WIDTH-1:0] fetch_addr, direct_ea, issue_ea;
  logic                  issue, retire;
  pdp_mem_opcode_s       mem_d;
  pdp_op7_opcode_s       op7_d;

  assign base_addr = START_ADDRESS;
  assign direct_ea = ir[7] ? {fetch_addr[11:7], ir[6:0]} : {5'b0, ir[6:0]};

`ifdef PDP8_INDIRECT_EN
  assign issue_ea = (state == IND_WAIT) ? ifu_rd_data : direct_ea;
`else
  assign issue_ea = direct_ea;
`endif

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_n;

  always_comb begin
    state_n     = state;
    issue       = 1'b0;
    retire      = 1'b0;
    ifu_rd_req  = 1'b0;
    ifu_rd_addr = '0;
    case (state)
      IDLE:       state_n = FETCH;
      FETCH: begin
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = fetch_addr;
        state_n     = FETCH_WAIT;
      end
      FETCH_WAIT: state_n = DECODE;
      DECODE: begin
`ifdef PDP8_INDIRECT_EN
        if (ir[11:9] < 3'd6 && ir[8]) state_n = IND_FETCH;
        else begin
          issue   = 1'b1;
          state_n = WAIT_STALL_HI;
        end
`else
        issue   = 1'b1;
        state_n = WAIT_STALL_HI;
`endif
      end
`ifdef PDP8_INDIRECT_EN
      IND_FETCH: begin
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = direct_ea;
        state_n     = IND_WAIT;
      end
      IND_WAIT: begin
        issue   = 1'b1;
        state_n = WAIT_STALL_HI;
      end
`endif
      WAIT_STALL_HI: if (stall) state_n = WAIT_STALL_LO;
      WAIT_STALL_LO: if (!stall) begin
        retire  = 1'b1;
        state_n = pdp_op7_opcode.HLT ? HALT : FETCH;
      end
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  // IOT and unlisted OPR encodings fall through to NOP so EXEC always sees one flag.
  always_comb begin
    mem_d = '0;
    op7_d = '0;
    case (ir[11:9])
      3'd0: mem_d.AND = 1'b1;
      3'd1: mem_d.TAD = 1'b1;
      3'd2: mem_d.ISZ = 1'b1;
      3'd3: mem_d.DCA = 1'b1;
      3'd4: mem_d.JMS = 1'b1;
      3'd5: mem_d.JMP = 1'b1;
      3'd6: op7_d.NOP = 1'b1;
      default:
        case (ir)
          12'o7001: op7_d.IAC     = 1'b1;
          12'o7004: op7_d.RAL     = 1'b1;
          12'o7006: op7_d.RTL     = 1'b1;
          12'o7010: op7_d.RAR     = 1'b1;
          12'o7012: op7_d.RTR     = 1'b1;
          12'o7020: op7_d.CML     = 1'b1;
          12'o7040: op7_d.CMA     = 1'b1;
          12'o7041: op7_d.CIA     = 1'b1;
          12'o7100: op7_d.CLL     = 1'b1;
          12'o7200: op7_d.CLA     = 1'b1;
          12'o7300: op7_d.CLA_CLL = 1'b1;
          12'o7402: op7_d.HLT     = 1'b1;
          12'o7500: op7_d.SMA     = 1'b1;
          12'o7440: op7_d.SZA     = 1'b1;
          12'o7420: op7_d.SNL     = 1'b1;
          12'o7410: op7_d.SKP     = 1'b1;
          12'o7510: op7_d.SPA     = 1'b1;
          12'o7450: op7_d.SNA     = 1'b1;
          12'o7430: op7_d.SZL     = 1'b1;
          default:  op7_d.NOP     = 1'b1;
        endcase
    endcase
    if (ir[11:9] < 3'd6) mem_d.mem_inst_addr = issue_ea;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_addr     <= START_ADDRESS;
      ir             <= '0;
      pdp_mem_opcode <= '0;
      pdp_op7_opcode <= '0;
    end else begin
      if (state == FETCH_WAIT) ir <= ifu_rd_data;
      if (issue) begin
        pdp_mem_opcode <= mem_d;
        pdp_op7_opcode <= op7_d;
      end
      if (retire) begin
        pdp_mem_opcode <= '0;
        pdp_op7_opcode <= '0;
        if (!pdp_op7_opcode.HLT) fetch_addr <= PC_value;
      end
    end
  end

endmodule

// File: tb/tb_pdp8_fetch_decode.sv
// Randomized bench for pdp8_fetch_decode against a table-driven decode model.
module tb_pdp8_fetch_decode;
  import pdp8_pkg::*;

`ifdef PDP8_INDIRECT_EN
  localparam bit IND_EN = 1'b1;
`else
  localparam bit IND_EN = 1'b0;
`endif

  localparam logic [11:0] OPR_TAB [20] = '{
    12'o7000, 12'o7001, 12'o7004, 12'o7006, 12'o7010, 12'o7012, 12'o7020,
    12'o7040, 12'o7041, 12'o7100, 12'o7200, 12'o7300, 12'o7402, 12'o7500,
    12'o7440, 12'o7420, 12'o7410, 12'o7510, 12'o7450, 12'o7430};

  logic            clk, reset_n, stall;
  logic [11:0]     PC_value, ifu_rd_addr, ifu_rd_data, base_addr;
  logic            ifu_rd_req;
  pdp_mem_opcode_s pdp_mem_opcode;
  pdp_op7_opcode_s pdp_op7_opcode;
  logic [11:0]     mem [4096];
  int              n_chk, n_err;

  pdp8_fetch_decode dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .PC_value(PC_value),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_data(ifu_rd_data),
    .base_addr(base_addr), .pdp_mem_opcode(pdp_mem_opcode), .pdp_op7_opcode(pdp_op7_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers one cycle after a request; otherwise the bus carries junk.
  always @(posedge clk)
    ifu_rd_data <= ifu_rd_req ? mem[ifu_rd_addr] : 12'($urandom);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %o expected %o", tag, got, exp);
    end
  endtask

  // Decode model: one-hot by opcode for memory refs, table search for OPR.
  task automatic model(input logic [11:0] pc, input logic [11:0] instr,
                       output logic [17:0] em, output logic [19:0] eo,
                       output logic ind, output logic [11:0] ea);
    logic [2:0] opc;
    opc = instr[11:9];
    ea  = instr[7] ? {pc[11:7], instr[6:0]} : {5'b0, instr[6:0]};
    ind = 1'b0;
    em  = '0;
    eo  = '0;
    if (opc < 3'd6) begin
      ind = IND_EN && instr[8];
      em  = {6'b100000 >> opc, ind ? mem[ea] : ea};
    end else begin
      eo = 20'h80000;
      if (opc == 3'd7)
        for (int i = 0; i < 20; i++)
          if (OPR_TAB[i] == instr) eo = 20'h80000 >> i;
    end
  endtask

  function automatic logic [11:0] gen_instr();
    logic [11:0] r;
    case ($urandom_range(0, 3))
      0:       r = 12'($urandom);
      1:       r = OPR_TAB[$urandom_range(0, 19)];
      2:       r = {3'($urandom_range(0, 5)), 9'($urandom)};
      default: r = {3'd6, 9'($urandom)};
    endcase
    if (r == 12'o7402) r = 12'o7401;
    return r;
  endfunction

  function automatic int outs_bad(input logic [17:0] em, input logic [19:0] eo);
    return int'(ifu_rd_req) + int'(pdp_mem_opcode !== em) + int'(pdp_op7_opcode !== eo);
  endfunction

  task automatic reset_release();
    reset_n = 1'b0;
    stall   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'({ifu_rd_req, ifu_rd_addr}), 32'd0);
    chk("rst_mem", 32'(pdp_mem_opcode), 32'd0);
    chk("rst_op7", 32'(pdp_op7_opcode), 32'd0);
    chk("rst_base", 32'(base_addr), 32'o0200);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("idle_req", 32'(ifu_rd_req), 32'd0);
    @(negedge clk);
    chk("first_fetch", 32'({ifu_rd_req, ifu_rd_addr}), 32'({1'b1, 12'o0200}));
  endtask

  // Entered at the negedge of the fetch cycle T; leaves at the negedge of the next T.
  task automatic run_instr(input logic [11:0] pc, input int hold_lo, input int hold_hi,
                           input logic [11:0] npc, input logic [11:0] ninstr);
    logic [17:0] em;
    logic [19:0] eo;
    logic        ind;
    logic [11:0] ea, instr;
    int          bad;
    instr = mem[pc];
    model(pc, instr, em, eo, ind, ea);
    @(negedge clk);
    bad = int'(ifu_rd_req);
    @(negedge clk);
    bad += outs_bad('0, '0);
    chk("pre_issue", 32'(bad), 32'd0);
    @(negedge clk);
    if (ind) begin
      chk("ind_req", 32'({ifu_rd_req, ifu_rd_addr}), 32'({1'b1, ea}));
      @(negedge clk);
      chk("ind_gap", 32'(outs_bad('0, '0)), 32'd0);
      @(negedge clk);
    end
    chk("mem_op", 32'(pdp_mem_opcode), 32'(em));
    chk("op7_op", 32'(pdp_op7_opcode), 32'(eo));
    chk("no_req", 32'(ifu_rd_req), 32'd0);
    bad = 0;
    repeat (hold_lo) begin
      PC_value = 12'($urandom);
      @(negedge clk);
      bad += outs_bad(em, eo);
    end
    stall = 1'b1;
    repeat (hold_hi) begin
      PC_value = 12'($urandom);
      @(negedge clk);
      bad += outs_bad(em, eo);
    end
    chk("hold", 32'(bad), 32'd0);
    mem[npc] = ninstr;
    stall    = 1'b0;
    PC_value = npc;
    @(negedge clk);
    PC_value = 12'($urandom);
    chk("clear", 32'({pdp_mem_opcode, pdp_op7_opcode}), 32'd0);
    if (instr == 12'o7402) begin
      bad = 0;
      repeat (50) begin
        @(negedge clk);
        bad += outs_bad('0, '0);
      end
      chk("halt", 32'(bad), 32'd0);
    end else
      chk("refetch", 32'({ifu_rd_req, ifu_rd_addr}), 32'({1'b1, npc}));
  endtask

  initial begin
    logic [11:0] pc, npc;
    n_chk = 0;
    n_err = 0;
    PC_value = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
    mem[12'o0200] = 12'o1205;
    mem[12'o0205] = 12'o0400;
    reset_release();
    run_instr(12'o0200, 10, 4, 12'o0201, 12'o1605);
    run_instr(12'o0201, 0, 1, 12'o0300, 12'o7300);
    run_instr(12'o0300, 2, 3, 12'o0301, 12'o6001);
    run_instr(12'o0301, 1, 2, 12'o7777, 12'o3377);
    pc = 12'o7777;
    for (int n = 0; n < 40; n++) begin
      npc = 12'($urandom);
      run_instr(pc, $urandom_range(0, 3), $urandom_range(1, 3), npc,
                (n == 39) ? 12'o7402 : gen_instr());
      pc = npc;
    end
    run_instr(pc, 1, 1, 12'o0000, 12'o0000);

    // Reset while the indirect pointer read is in flight; its data must not issue.
    mem[12'o0200] = 12'o1605;
    mem[12'o0205] = 12'o0400;
    reset_release();
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    mem[12'o0200] = 12'o7001;
    #1;
    chk("midrst_out", 32'({ifu_rd_req, pdp_mem_opcode, pdp_op7_opcode}), 32'd0);
    reset_release();
    run_instr(12'o0200, 0, 1, 12'o0400, 12'o7000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pdp8_fetch_decode.md
# pdp8_fetch_decode

Instruction fetch and decode stage of the PDP-8 pipeline, directly upstream of the EXEC unit. It fetches each 12-bit instruction from memory_pdp and resolves the effective address, including one level of indirection. It then presents the decoded memory-reference or OPR micro-op to EXEC and holds it there. It uses EXEC's `stall` and `PC_value` as the retire handshake and as the next fetch address.

## Interface
Parameters (from pdp8_pkg; not overridable):
- `ADDR_WIDTH`, 12: address width.
- `DATA_WIDTH`, 12: instruction/data width.
- `START_ADDRESS`, 12'o0200: address of the first fetch.

Ports:
- `clk`  in  1  free-running clock; all state on rising edge.
- `reset_n`  in  1  active-low asynchronous reset. One clock; reset is asynchronous and active-low.
- `stall`  in  1  from EXEC; high while EXEC executes the issued instruction.
- `PC_value`  in  12  from EXEC; next PC, valid on the cycle `stall` falls.
- `ifu_rd_req`  out  1  memory read request; one-cycle pulse.
- `ifu_rd_addr`  out  12  read address; valid with `ifu_rd_req`.
- `ifu_rd_data`  in  12  read data; valid exactly one cycle after `ifu_rd_req`.
- `base_addr`  out  12  constant `START_ADDRESS`.
- `pdp_mem_opcode`  out  pdp_mem_opcode_s  one-hot AND/TAD/ISZ/DCA/JMS/JMP plus `mem_inst_addr` (effective address, 12 bits).
- `pdp_op7_opcode`  out  pdp_op7_opcode_s  one-hot NOP, IAC, RAL, RTL, RAR, RTR, CML, CMA, CIA, CLL, CLA, CLA_CLL, HLT, SMA, SZA, SNL, SKP, SPA, SNA, SZL.

## Operation
- States: IDLE, FETCH, FETCH_WAIT, DECODE, IND_FETCH, IND_WAIT, WAIT_STALL_HI, WAIT_STALL_LO, HALT.
- Reset: state IDLE; `fetch_addr` = `START_ADDRESS`; all outputs zero except `base_addr`.
- IDLE→FETCH unconditionally.
- FETCH: `ifu_rd_req`=1 and `ifu_rd_addr`=`fetch_addr`; next state FETCH_WAIT.
- FETCH_WAIT: `ifu_rd_data` is latched into `IR`; next state DECODE.
- DECODE field layout: opcode=`IR[11:9]`, indirect bit I=`IR[8]`, page bit Z=`IR[7]`, offset=`IR[6:0]`.
- DECODE address: direct EA = Z ? {`fetch_addr[11:7]`, offset} : {5'b0, offset}.
- DECODE routing: opcodes 0–5 with I=1 go to IND_FETCH. All other instructions load the outputs and go to WAIT_STALL_HI.
- IND_FETCH: read request at the direct EA.
- IND_WAIT: `mem_inst_addr` = `ifu_rd_data`. Outputs load and the state becomes WAIT_STALL_HI. Single-level indirection only; auto-index locations 0010–0017 are not incremented.
- OPR (opcode 7) decodes by exact octal match: 7000 NOP, 7001 IAC, 7004 RAL, 7006 RTL, 7010 RAR, 7012 RTR, 7020 CML, 7040 CMA, 7041 CIA, 7100 CLL, 7200 CLA, 7300 CLA_CLL, 7402 HLT, 7500 SMA, 7440 SZA, 7420 SNL, 7410 SKP, 7510 SPA, 7450 SNA, 7430 SZL.
- OPR encodings not in that list, and any IOT (opcode 6), issue as op7 NOP. `mem_inst_addr` is 0 for all op7 issues.
- Exactly one output flag is set per issued instruction.
- WAIT_STALL_HI: wait for `stall`=1, then go to WAIT_STALL_LO. Outputs are held stable with no timeout.
- WAIT_STALL_LO, on the edge where `stall`=0:
  - If the issued instruction was HLT, go to HALT.
  - Otherwise clear both opcode structs to zero, latch `fetch_addr` from `PC_value`, and go to FETCH.
- HALT: terminal state; no requests and outputs zero until reset.

## Timing
- Let T be the cycle with `ifu_rd_req` high for an instruction fetch.
- Direct instruction: outputs valid from T+3.
- Indirect instruction: second request at T+3; outputs valid from T+5.
- First fetch: the FETCH cycle is the second cycle after `reset_n` deasserts.
- Retire to refetch: `stall` is sampled low at edge E; outputs read zero and `ifu_rd_req` is high in the cycle after E.
- Outputs change only at the issue edge and the clear edge; they are never glitch-updated mid-instruction.
- `stall` already high when WAIT_STALL_HI is entered is accepted on the next edge.
- Reset mid-operation (any state) returns everything to reset values immediately. Read data returned afterward is ignored.
- `fetch_addr` wraps mod 4096, with no special case at 7777.

## Configuration
- `PDP8_INDIRECT_EN` defined: indirect addressing behaves as described, and IND_FETCH/IND_WAIT exist.
- `PDP8_INDIRECT_EN` undefined:
  - I is ignored and the direct EA is always issued.
  - IND states are not compiled.
  - Every instruction issues at T+3.

## Test plan
- Reset, mem[0200]=1205 → `ifu_rd_req` with addr 0200 at second cycle after reset release; at T+3 TAD=1 and `mem_inst_addr`=0205, all other flags 0.
- mem[0200]=1605, mem[0205]=0400 (INDIRECT_EN) → second read at 0205 on T+3; at T+5 TAD=1 and `mem_inst_addr`=0400. Without the macro: TAD, 0205 at T+3, no second read.
- mem[0200]=7300 → one read only; CLA_CLL=1 and `pdp_mem_opcode`=0 at T+3. mem[0200]=6001 → NOP=1.
- After issue, hold `stall`=0 for 10 cycles → no `ifu_rd_req`. Then `stall`=1 for 4 cycles, drop with `PC_value`=0201 → next cycle outputs zero, `ifu_rd_req`=1, addr 0201.
- mem[0200]=7402 → HLT=1; after the stall pulse, outputs zero and no `ifu_rd_req` for 50 cycles.
- `reset_n` pulsed low during IND_WAIT → outputs zero immediately; refetch at 0200 after release; stale `ifu_rd_data` is not issued.
